// File: rtl/coproc_dma_pkg.sv
// Shared definitions for the coproc_dma_copier block: default widths,
// the controller state encoding and the constant byte-enable value.
package coproc_dma_pkg;

    localparam int DEF_ADDR_W     = 14;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LEN_W      = 14;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam logic [3:0] BYTEENA_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/coproc_dma_copier_if.sv
// Avalon-MM bus between the DMA copier (master) and the main memory s1/s2
// port (slave): word address, 32-bit data, no waitrequest, read latency 1.
interface coproc_dma_copier_if
    import coproc_dma_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write,
        output avm_byteenable,
        output avm_writedata,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write,
        input  avm_byteenable,
        input  avm_writedata,
        output avm_readdata
    );

endinterface

// File: rtl/coproc_dma_fifo.sv
// Synchronous read-data FIFO, DATA_W x DEPTH (DEPTH a power of two, >= 2).
// Head word is visible combinationally; clear_n is an asynchronous clear.
module coproc_dma_fifo #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    logic [DATA_W-1:0] store [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign head    = store[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Data storage: written on push, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping with asynchronous clear.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/coproc_dma_copier.sv
// Block-copy DMA master for the coprocessor's single-port main memory.
// Accepts (src, dst, len) commands, reads words into a small FIFO and writes
// them back out, one memory access per cycle, writes taking priority.
// Optional feature macro: COPROC_DMA_FILL_EN adds cmd_fill/cmd_pattern,
// turning a command into a pattern fill with no reads.
module coproc_dma_copier
    import coproc_dma_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_src,
    input  logic [ADDR_W-1:0]   cmd_dst,
    input  logic [LEN_W-1:0]    cmd_len,
`ifdef COPROC_DMA_FILL_EN
    input  logic                cmd_fill,
    input  logic [DATA_W-1:0]   cmd_pattern,
`endif
    output logic                busy,
    output logic                done,
    coproc_dma_copier_if.master avm
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rd_cnt;
    logic [LEN_W-1:0]  wr_cnt;
    logic              rd_pending;
    logic              fill_q;
    logic [DATA_W-1:0] pattern_q;

    logic              accept;
    logic              do_read;
    logic              do_write;
    logic              last_write;
    logic              room;

    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    assign accept     = (state == IDLE) && cmd_valid;
    assign last_write = (wr_cnt == LEN_W'(len_q - 1'b1));
    // A read may only be issued if its data, plus any read still in flight,
    // will fit in the FIFO when it lands.
    assign room       = (int'(fifo_count) + int'(rd_pending)) < FIFO_DEPTH;

    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle access arbitration (write first, then read).
    always_comb begin
        state_next = state;
        do_read    = 1'b0;
        do_write   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_next = (cmd_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (fill_q) begin
                    do_write = 1'b1;
                end else if (!fifo_empty) begin
                    do_write = 1'b1;
                end else if ((rd_cnt < len_q) && room && !fifo_full) begin
                    do_read = 1'b1;
                end
                if (do_write && last_write) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Avalon master outputs; everything is zero whenever no access is issued.
    always_comb begin
        avm.avm_chipselect = do_read || do_write;
        avm.avm_write      = do_write;
        avm.avm_byteenable = (do_read || do_write) ? BYTEENA_ALL : 4'h0;
        avm.avm_address    = '0;
        avm.avm_writedata  = '0;
        if (do_write) begin
            avm.avm_address   = dst_q + ADDR_W'(wr_cnt);
            avm.avm_writedata = fill_q ? pattern_q : fifo_head;
        end else if (do_read) begin
            avm.avm_address   = src_q + ADDR_W'(rd_cnt);
        end
    end

    // Command latch, read/write counters and the in-flight read flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= do_read;
            if (accept) begin
                src_q  <= cmd_src;
                dst_q  <= cmd_dst;
                len_q  <= cmd_len;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (do_read) begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
                if (do_write) begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

`ifdef COPROC_DMA_FILL_EN
    // Fill mode and pattern are captured with the command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_q    <= 1'b0;
            pattern_q <= '0;
        end else if (accept) begin
            fill_q    <= cmd_fill;
            pattern_q <= cmd_pattern;
        end
    end
`else
    assign fill_q    = 1'b0;
    assign pattern_q = '0;
`endif

    // Read data arrives one cycle after the read and is pushed then.
    coproc_dma_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .clear_n   (reset_n),
        .push      (rd_pending),
        .push_data (avm.avm_readdata),
        .pop       (do_write && !fill_q),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule
